// File: rtl/ctrl_pkg.sv
// Shared definitions for the five-phase control sequencer: state encoding,
// instruction-class constants and small opcode-classification helpers.
package ctrl_pkg;

    localparam int CTRL_PC_W = 16;

    // State index doubles as the debug phase value (IDLE=0, P1..P5=1..5, HALT=6)
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_P2   = 3'd2,
        ST_P3   = 3'd3,
        ST_P4   = 3'd4,
        ST_P5   = 3'd5,
        ST_HALT = 3'd6
    } ctrl_state_e;

    // op1 instruction classes
    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_BR  = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    // op2 sub-classes of the BR group
    localparam logic [2:0] OP2_LI   = 3'b000;
    localparam logic [2:0] OP2_ADDI = 3'b001;
    localparam logic [2:0] OP2_CMPI = 3'b010;
    localparam logic [2:0] OP2_B    = 3'b100;
    localparam logic [2:0] OP2_BC   = 3'b111;

    // ALU opcodes the sequencer cares about by name
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_CMP = 4'd5;
    localparam logic [3:0] ALU_HLT = 4'd15;

    // ALU opcodes whose flag results become architectural
    function automatic logic aluSetsFlags(input logic [3:0] opc);
        return (opc <= 4'd6) || ((opc >= 4'd8) && (opc <= 4'd11));
    endfunction

    // ALU opcodes that write a result back (CMP only sets flags)
    function automatic logic aluWritesReg(input logic [3:0] opc);
        return (opc <= 4'd4) || (opc == 4'd6) || ((opc >= 4'd8) && (opc <= 4'd11));
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: splits IR into ALU control fields,
// register addresses and the class bits the sequencer needs.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic [1:0]  o_op1,
    output logic [2:0]  o_op2,
    output logic [2:0]  o_cond,
    output logic [3:0]  o_opcode,
    output logic [3:0]  o_d,
    output logic [2:0]  o_raAddr,
    output logic [2:0]  o_rbAddr,
    output logic [2:0]  o_wbAddr,
    output logic        o_isLd,
    output logic        o_isSt,
    output logic        o_isBr,
    output logic        o_wrEn,
    output logic        o_flagEn
);

    // Field split and classification; unused fields of a class stay zero
    always_comb begin
        o_op1    = i_ir[15:14];
        o_op2    = 3'd0;
        o_cond   = 3'd0;
        o_opcode = 4'd0;
        o_d      = 4'd0;
        o_raAddr = i_ir[13:11];
        o_rbAddr = i_ir[10:8];
        o_wbAddr = i_ir[13:11];
        o_isLd   = 1'b0;
        o_isSt   = 1'b0;
        o_isBr   = 1'b0;
        o_wrEn   = 1'b0;
        o_flagEn = 1'b0;
        case (i_ir[15:14])
            OP1_LD: begin
                o_isLd = 1'b1;
                o_wrEn = 1'b1;
            end
            OP1_ST: begin
                o_isSt = 1'b1;
            end
            OP1_BR: begin
                o_op2    = i_ir[13:11];
                o_cond   = i_ir[10:8];
                o_isBr   = (i_ir[13:11] == OP2_B) || (i_ir[13:11] == OP2_BC);
                o_wrEn   = (i_ir[13:11] == OP2_LI);
                o_flagEn = (i_ir[13:11] == OP2_ADDI) || (i_ir[13:11] == OP2_CMPI);
            end
            default: begin
                o_opcode = i_ir[7:4];
                o_d      = i_ir[3:0];
                o_wrEn   = aluWritesReg(i_ir[7:4]);
                o_flagEn = aluSetsFlags(i_ir[7:4]);
            end
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Five-phase multi-cycle control sequencer for the 16-bit core.
// Owns PC, IR, DR, MDR and the S/Z/C/V flags; generates register-file and
// data-memory strobes and the ALU control fields.
// Optional build macro CTRL_SKIP_P4_EN: non-memory instructions bypass P4.
// ra_rdata carries the register-file Ra read port value, forwarded as store data.
// PC_W must not exceed 16 (branch targets come from the 16-bit DR).
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int              PC_W   = CTRL_PC_W,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    output logic [2:0]      ra_addr,
    output logic [2:0]      rb_addr,
    output logic [2:0]      wb_addr,
    output logic [15:0]     wb_data,
    output logic            reg_we,
    input  logic [15:0]     ra_rdata,
    output logic [1:0]      alu_op1,
    output logic [2:0]      alu_op2,
    output logic [3:0]      alu_opcode,
    output logic [2:0]      alu_cond,
    output logic [3:0]      alu_d,
    input  logic [15:0]     alu_out,
    input  logic            alu_s,
    input  logic            alu_z,
    input  logic            alu_c,
    input  logic            alu_v,
    input  logic            alu_hlt,
    output logic            flag_s,
    output logic            flag_z,
    output logic            flag_c,
    output logic            flag_v,
    output logic [15:0]     dmem_addr,
    output logic [15:0]     dmem_wdata,
    output logic            dmem_we,
    input  logic [15:0]     dmem_rdata,
    output logic [2:0]      phase,
    output logic            halted
);

    ctrl_state_e     r_state;
    ctrl_state_e     w_stateNext;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [15:0]     r_dr;
    logic [15:0]     r_mdr;
    logic [3:0]      r_flags;

    logic [1:0] w_op1;
    logic [2:0] w_op2;
    logic [2:0] w_cond;
    logic [3:0] w_opcode;
    logic [3:0] w_d;
    logic       w_isLd;
    logic       w_isSt;
    logic       w_isBr;
    logic       w_wrEn;
    logic       w_flagEn;

    ctrl_decode u_decode (
        .i_ir     (r_ir),
        .o_op1    (w_op1),
        .o_op2    (w_op2),
        .o_cond   (w_cond),
        .o_opcode (w_opcode),
        .o_d      (w_d),
        .o_raAddr (ra_addr),
        .o_rbAddr (rb_addr),
        .o_wbAddr (wb_addr),
        .o_isLd   (w_isLd),
        .o_isSt   (w_isSt),
        .o_isBr   (w_isBr),
        .o_wrEn   (w_wrEn),
        .o_flagEn (w_flagEn)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_stateNext;
    end

    // Next-state logic plus state-decoded strobes and ALU field gating
    always_comb begin
        w_stateNext = r_state;
        reg_we      = 1'b0;
        dmem_we     = 1'b0;
        halted      = 1'b0;
        alu_op1     = 2'd0;
        alu_op2     = 3'd0;
        alu_opcode  = 4'd0;
        alu_cond    = 3'd0;
        alu_d       = 4'd0;
        case (r_state)
            ST_IDLE: if (run) w_stateNext = ST_P1;
            ST_P1:   w_stateNext = ST_P2;
            ST_P2:   w_stateNext = ST_P3;
            ST_P3: begin
                if (alu_hlt)
                    w_stateNext = ST_HALT;
`ifdef CTRL_SKIP_P4_EN
                else if (!(w_isLd || w_isSt))
                    w_stateNext = ST_P5;
`endif
                else
                    w_stateNext = ST_P4;
            end
            ST_P4: begin
                dmem_we     = w_isSt;
                w_stateNext = ST_P5;
            end
            ST_P5: begin
                reg_we      = w_wrEn;
                w_stateNext = ST_P1;
            end
            ST_HALT: halted = 1'b1;
            default: w_stateNext = ST_IDLE;
        endcase
        if (r_state inside {ST_P2, ST_P3, ST_P4, ST_P5}) begin
            alu_op1    = w_op1;
            alu_op2    = w_op2;
            alu_opcode = w_opcode;
            alu_cond   = w_cond;
            alu_d      = w_d;
        end
    end

    // Datapath registers: IR in P1, DR/flags in P3 (unless halting), MDR in P4, PC in P5
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RST_PC;
            r_ir    <= 16'd0;
            r_dr    <= 16'd0;
            r_mdr   <= 16'd0;
            r_flags <= 4'd0;
        end else begin
            case (r_state)
                ST_P1: r_ir <= imem_rdata;
                ST_P3: begin
                    if (!alu_hlt) begin
                        r_dr <= alu_out;
                        if (w_flagEn) r_flags <= {alu_s, alu_z, alu_c, alu_v};
                    end
                end
                ST_P4: if (w_isLd) r_mdr <= dmem_rdata;
                ST_P5: r_pc <= w_isBr ? r_dr[PC_W-1:0] : r_pc + PC_W'(1);
                default: ;
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign dmem_addr  = r_dr;
    assign dmem_wdata = ra_rdata;
    assign wb_data    = w_isLd ? r_mdr : r_dr;
    assign flag_s     = r_flags[3];
    assign flag_z     = r_flags[2];
    assign flag_c     = r_flags[1];
    assign flag_v     = r_flags[0];
    assign phase      = r_state;

endmodule
